vdp_vram_arb: RTL

//  Single-port VRAM access arbiter/sequencer for vdp99, between the CPU data port and the vdp_fsm DMA reader.

---
 rtl/vdp_vram_arb_if.sv | 36 +++
 rtl/vdp_vram_arb.sv | 89 ++++++++
 2 files changed

// File: rtl/vdp_vram_arb_if.sv
// vdp_vram_arb_if: CPU data port, DMA reader and VRAM signal bundle for the VRAM arbiter
interface vdp_vram_arb_if #(
  parameter int AW = 13
);
  logic          cpu_wr_tick;
  logic          cpu_rd_tick;
  logic          cpu_addr_ld;
  logic [AW-1:0] cpu_addr;
  logic          cpu_prefetch;
  logic [7:0]    cpu_din;
  logic [7:0]    cpu_dout;
  logic          cpu_busy;
  logic          cpu_ovr;
  logic          dma_req;
  logic [AW-1:0] dma_addr;
  logic          dma_gnt;
  logic          dma_valid;
  logic [7:0]    dma_data;
  logic [AW-1:0] mem_addr;
  logic          mem_re;
  logic          mem_we;
  logic [7:0]    mem_din;
  logic [7:0]    mem_dout;
  modport master (
    input  cpu_wr_tick, cpu_rd_tick, cpu_addr_ld, cpu_addr, cpu_prefetch, cpu_din,
    input  dma_req, dma_addr, mem_dout,
    output cpu_dout, cpu_busy, cpu_ovr, dma_gnt, dma_valid, dma_data,
    output mem_addr, mem_re, mem_we, mem_din
  );
  modport slave (
    output cpu_wr_tick, cpu_rd_tick, cpu_addr_ld, cpu_addr, cpu_prefetch, cpu_din,
    output dma_req, dma_addr, mem_dout,
    input  cpu_dout, cpu_busy, cpu_ovr, dma_gnt, dma_valid, dma_data,
    input  mem_addr, mem_re, mem_we, mem_din
  );
endinterface

// File: rtl/vdp_vram_arb.sv
// vdp_vram_arb: single-port VRAM arbiter between the CPU data port and the DMA reader
module vdp_vram_arb #(
  parameter int VRAM_SIZE    = 8192,
  parameter int STARVE_LIMIT = 64
) (
  input logic            pxclk,
  input logic            reset,
  vdp_vram_arb_if.master bus
);
  localparam int AW = $clog2(VRAM_SIZE);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  typedef enum logic [1:0] {G_IDLE, G_DMA, G_WR, G_PF} grant_t;
  grant_t        grant;
  logic [AW-1:0] addr;
  logic [7:0]    wbuf;
  logic [7:0]    rd_latch;
  logic          wbuf_valid;
  logic          pf_pending;
  logic          tag_cpu;
  logic          tag_dma;
  logic          ovr;
  logic [SW-1:0] starve_cnt;
  logic          pending;
  logic          preempt;
  logic          busy;
  logic          cpu_grant;
  always_comb begin
    pending   = wbuf_valid | pf_pending;
    preempt   = pending && starve_cnt == SW'(STARVE_LIMIT);
    busy      = pending | tag_cpu;
    grant     = reset ? G_IDLE :
                (bus.dma_req && !preempt) ? G_DMA :
                wbuf_valid ? G_WR :
                pf_pending ? G_PF : G_IDLE;
    cpu_grant = grant == G_WR || grant == G_PF;
  end
  assign bus.dma_gnt   = grant == G_DMA;
  assign bus.mem_re    = grant == G_DMA || grant == G_PF;
  assign bus.mem_we    = grant == G_WR;
  assign bus.mem_addr  = grant == G_DMA ? bus.dma_addr : addr;
  assign bus.mem_din   = wbuf;
  assign bus.cpu_dout  = rd_latch;
  assign bus.cpu_busy  = busy;
  assign bus.cpu_ovr   = ovr;
  assign bus.dma_valid = tag_dma;
  assign bus.dma_data  = tag_dma ? bus.mem_dout : 8'h00;
  always_ff @(posedge pxclk or posedge reset)
    if (reset) begin
      addr       <= '0;
      wbuf       <= '0;
      rd_latch   <= '0;
      wbuf_valid <= 1'b0;
      pf_pending <= 1'b0;
      tag_cpu    <= 1'b0;
      tag_dma    <= 1'b0;
      ovr        <= 1'b0;
      starve_cnt <= '0;
    end else begin
      tag_cpu    <= grant == G_PF;
      tag_dma    <= grant == G_DMA;
      starve_cnt <= (!pending || cpu_grant) ? '0 :
                    starve_cnt == SW'(STARVE_LIMIT) ? starve_cnt : starve_cnt + 1'b1;
      // a returning CPU read can never coincide with a write grant, the latch has one source per cycle
      if (tag_cpu)
        rd_latch <= bus.mem_dout;
      else if (grant == G_WR)
        rd_latch <= wbuf;
      if (bus.cpu_addr_ld) begin
        addr       <= bus.cpu_addr;
        pf_pending <= bus.cpu_prefetch;
        wbuf_valid <= 1'b0;
        ovr        <= 1'b0;
      end else begin
        if (cpu_grant)
          addr <= addr + 1'b1;
        if (grant == G_WR)
          wbuf_valid <= 1'b0;
        if (grant == G_PF)
          pf_pending <= 1'b0;
        if ((bus.cpu_wr_tick || bus.cpu_rd_tick) && (busy || (bus.cpu_wr_tick && bus.cpu_rd_tick)))
          ovr <= 1'b1;
        if (!busy && bus.cpu_wr_tick) begin
          wbuf       <= bus.cpu_din;
          wbuf_valid <= 1'b1;
        end else if (!busy && bus.cpu_rd_tick)
          pf_pending <= 1'b1;
      end
    end
endmodule
